// File: rtl/peripheral_bus_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_initiator_pkg
// Description : Shared types and constants for the Wishbone-to-peripheral-bus
//               initiator: FSM state encoding, bus widths, device-ID field
//               position and the peripheral request bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package peripheral_bus_initiator_pkg;

    localparam int c_WB_ADR_W   = 24;
    localparam int c_ADDR_W     = 16;
    localparam int c_DATA_W     = 32;
    localparam int c_SEL_W      = 4;
    localparam int c_DEV_ID_MSB = 15;
    localparam int c_DEV_ID_LSB = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    // Everything driven onto the peripheral bus during one access
    typedef struct packed {
        logic                en;
        logic                we;
        logic                oe;
        logic [c_SEL_W-1:0]  sel;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
    } pbus_t;

    // Builds the peripheral-side bundle for a freshly accepted request
    function automatic pbus_t pbus_request(input logic                we,
                                           input logic [c_SEL_W-1:0]  sel,
                                           input logic [c_ADDR_W-1:0] addr,
                                           input logic [c_DATA_W-1:0] wdata);
        pbus_t p;
        p.en    = 1'b1;
        p.we    = we;
        p.oe    = ~we;
        p.sel   = sel;
        p.addr  = addr;
        p.wdata = wdata;
        return p;
    endfunction

    // Device-ID field of a peripheral address (upper nibble selects the device)
    function automatic logic [c_DEV_ID_MSB-c_DEV_ID_LSB:0] dev_id(input logic [c_ADDR_W-1:0] addr);
        return addr[c_DEV_ID_MSB:c_DEV_ID_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_bus_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_initiator_if
// Description : Wishbone slave-side and peripheral-bus signals of the
//               initiator. 'master' is the initiator's view, 'slave' is the
//               view of the environment (Wishbone host + peripherals).
// Revision    : 1.0 - initial release
// ============================================================================
interface peripheral_bus_initiator_if;
    import peripheral_bus_initiator_pkg::*;

    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [c_SEL_W-1:0]    wb_sel_i;
    logic [c_WB_ADR_W-1:0] wb_adr_i;
    logic [c_DATA_W-1:0]   wb_data_i;
    logic                  wb_ack_o;
    logic                  wb_stall_o;
    logic                  wb_error_o;
    logic [c_DATA_W-1:0]   wb_data_o;

    logic                  peripheralEnable;
    logic [c_ADDR_W-1:0]   peripheralBus_address;
    logic [c_SEL_W-1:0]    peripheralBus_byteSelect;
    logic [c_DATA_W-1:0]   peripheralBus_dataWrite;
    logic                  peripheralBus_we;
    logic                  peripheralBus_oe;
    logic                  peripheralBus_busy;
    logic [c_DATA_W-1:0]   peripheralBus_dataRead;

    modport master (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
        output wb_ack_o, wb_stall_o, wb_error_o, wb_data_o,
        output peripheralEnable, peripheralBus_address, peripheralBus_byteSelect,
        output peripheralBus_dataWrite, peripheralBus_we, peripheralBus_oe,
        input  peripheralBus_busy, peripheralBus_dataRead
    );

    modport slave (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
        input  wb_ack_o, wb_stall_o, wb_error_o, wb_data_o,
        input  peripheralEnable, peripheralBus_address, peripheralBus_byteSelect,
        input  peripheralBus_dataWrite, peripheralBus_we, peripheralBus_oe,
        output peripheralBus_busy, peripheralBus_dataRead
    );

endinterface
`default_nettype wire

// File: rtl/peripheral_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_timeout
// Description : Access-cycle counter for the initiator. Counts cycles while
//               'start' is high, returns to zero on 'clear', and flags
//               'expired' during the last permitted access cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_LAST  = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0;

    logic [c_CNT_W-1:0] r_count;

    // Count elapsed access cycles; saturate once the limit is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (start && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_CNT_W'(c_LAST));

endmodule
`default_nettype wire

// File: rtl/peripheral_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_bus_initiator
// Description : Bridges single Wishbone transactions onto a simple
//               enable/we/oe peripheral bus. IDLE -> ACCESS (waits on busy)
//               -> RESPOND (one-cycle ack). All outputs registered.
//               Optional access timeout: define PERIPHERAL_BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_bus_initiator
    import peripheral_bus_initiator_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    peripheral_bus_initiator_if.master  bus
);

    state_t              r_state;
    pbus_t               r_pbus;
    logic                r_ack;
    logic                r_stall;
    logic [c_DATA_W-1:0] r_rdata;

    // Only the low 16 address bits reach the peripheral bus
    logic w_unused_adr_hi;
    assign w_unused_adr_hi = ^bus.wb_adr_i[c_WB_ADR_W-1:c_ADDR_W];

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    logic r_err;
    logic r_timed_out;
    logic w_expired;

    // Counter runs only in ACCESS and is zero on every entry to it
    peripheral_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (r_state == ST_ACCESS),
        .clear   (r_state != ST_ACCESS),
        .expired (w_expired)
    );
`else
    // Timeout limit is meaningless when the counter is not built
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Transaction FSM with all bus-facing outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pbus  <= '0;
            r_ack   <= 1'b0;
            r_stall <= 1'b0;
            r_rdata <= '0;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
            r_err       <= 1'b0;
            r_timed_out <= 1'b0;
`endif
        end else begin
            r_ack <= 1'b0;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.wb_cyc_i && bus.wb_stb_i) begin
                        r_pbus  <= pbus_request(bus.wb_we_i, bus.wb_sel_i,
                                                bus.wb_adr_i[c_ADDR_W-1:0], bus.wb_data_i);
                        r_stall <= 1'b1;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.wb_cyc_i) begin
                        // Host abandoned the cycle: silent return to IDLE
                        r_pbus  <= '0;
                        r_stall <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (!bus.peripheralBus_busy) begin
                        if (!r_pbus.we) begin
                            r_rdata <= bus.peripheralBus_dataRead;
                        end
                        r_pbus  <= '0;
                        r_state <= ST_RESPOND;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
                        r_timed_out <= 1'b0;
                    end else if (w_expired) begin
                        r_pbus      <= '0;
                        r_timed_out <= 1'b1;
                        r_state     <= ST_RESPOND;
`endif
                    end
                end
                ST_RESPOND: begin
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
                    if (r_timed_out) begin
                        r_err   <= 1'b1;
                        r_rdata <= '1;
                    end else begin
                        r_ack <= 1'b1;
                    end
                    r_timed_out <= 1'b0;
`else
                    r_ack <= 1'b1;
`endif
                    r_stall <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_pbus  <= '0;
                    r_stall <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wb_ack_o                 = r_ack;
    assign bus.wb_stall_o               = r_stall;
    assign bus.wb_data_o                = r_rdata;
    assign bus.peripheralEnable         = r_pbus.en;
    assign bus.peripheralBus_address    = r_pbus.addr;
    assign bus.peripheralBus_byteSelect = r_pbus.sel;
    assign bus.peripheralBus_dataWrite  = r_pbus.wdata;
    assign bus.peripheralBus_we         = r_pbus.we;
    assign bus.peripheralBus_oe         = r_pbus.oe;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    assign bus.wb_error_o               = r_err;
`else
    assign bus.wb_error_o               = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_bus_initiator
// Description : Self-checking bench for peripheral_bus_initiator. Expected
//               responses are queued at request time and matched against
//               every ack/error the DUT produces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_bus_initiator;
    import peripheral_bus_initiator_pkg::*;

    localparam int c_TIMEOUT = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    resp_t       sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rdata;

    always #5 clk = ~clk;

    peripheral_bus_initiator_if bus();

    peripheral_bus_initiator #(
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_resp(input logic err, input logic [31:0] data);
        resp_t r;
        r.err  = err;
        r.data = data;
        sb.push_back(r);
    endtask

    task automatic drive_req(input logic we, input logic [3:0] sel,
                             input logic [23:0] adr, input logic [31:0] wdata);
        bus.wb_cyc_i  = 1'b1;
        bus.wb_stb_i  = 1'b1;
        bus.wb_we_i   = we;
        bus.wb_sel_i  = sel;
        bus.wb_adr_i  = adr;
        bus.wb_data_i = wdata;
    endtask

    // Complete transaction with an idle device; entered and left on a negedge
    task automatic txn(input logic we, input logic [3:0] sel, input logic [23:0] adr,
                       input logic [31:0] wdata, input logic [31:0] rdata);
        logic [15:0] a;
        bit          seen;
        a = adr[15:0];
        bus.peripheralBus_busy     = 1'b0;
        bus.peripheralBus_dataRead = rdata;
        if (!we) exp_rdata = rdata;
        push_resp(1'b0, exp_rdata);
        drive_req(we, sel, adr, wdata);
        @(negedge clk);
        check_eq("txn_enable", bus.peripheralEnable, 1);
        check_eq("txn_address", bus.peripheralBus_address, a);
        bus.wb_stb_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bus.wb_ack_o || bus.wb_error_o) seen = 1;
        end
        if (!seen) check_eq("txn_ack_timeout", 0, 1);
    endtask

    // Scoreboard: every response cycle must match the oldest queued entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (bus.wb_ack_o === 1'b1 || bus.wb_error_o === 1'b1)) begin
            check_eq("ack_err_exclusive", bus.wb_ack_o & bus.wb_error_o, 0);
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_resp", 1, 0);
            end else begin
                resp_t e;
                e = sb.pop_front();
                check_eq("sb_kind_err", bus.wb_error_o, e.err);
                check_eq("sb_data", bus.wb_data_o, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  en_cnt;
        int  stall_bad;
        bit  seen;
        bit  got_ack;

        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_sel_i = '0;   bus.wb_adr_i = '0;   bus.wb_data_i = '0;
        bus.peripheralBus_busy = 1'b0;
        bus.peripheralBus_dataRead = '0;
        exp_rdata = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_eq("rst_ack", bus.wb_ack_o, 0);
        check_eq("rst_stall", bus.wb_stall_o, 0);
        check_eq("rst_error", bus.wb_error_o, 0);
        check_eq("rst_data", bus.wb_data_o, 0);
        check_eq("rst_enable", bus.peripheralEnable, 0);
        check_eq("rst_address", bus.peripheralBus_address, 0);
        check_eq("rst_we_oe", {bus.peripheralBus_we, bus.peripheralBus_oe}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- basic read, minimum latency ----------------
        bus.peripheralBus_dataRead = 32'hA5A5_0001;
        exp_rdata = 32'hA5A5_0001;
        push_resp(1'b0, exp_rdata);
        drive_req(1'b0, 4'hF, 24'h001004, 32'h0);
        @(negedge clk);
        check_eq("rd_enable", bus.peripheralEnable, 1);
        check_eq("rd_address", bus.peripheralBus_address, 16'h1004);
        check_eq("rd_oe", bus.peripheralBus_oe, 1);
        check_eq("rd_we", bus.peripheralBus_we, 0);
        check_eq("rd_stall", bus.wb_stall_o, 1);
        check_eq("rd_no_early_ack", bus.wb_ack_o, 0);
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        check_eq("rd_enable_drop", bus.peripheralEnable, 0);
        check_eq("rd_oe_drop", bus.peripheralBus_oe, 0);
        check_eq("rd_address_zero", bus.peripheralBus_address, 0);
        check_eq("rd_stall_respond", bus.wb_stall_o, 1);
        check_eq("rd_ack_not_n1", bus.wb_ack_o, 0);
        @(negedge clk);
        check_eq("rd_ack_n2", bus.wb_ack_o, 1);
        check_eq("rd_data", bus.wb_data_o, 32'hA5A5_0001);
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);

        // ---------------- write, data_o unchanged ----------------
        bus.peripheralBus_dataRead = 32'hDEAD_BEEF;
        push_resp(1'b0, exp_rdata);
        drive_req(1'b1, 4'b0011, 24'h002010, 32'h1234_5678);
        @(negedge clk);
        check_eq("wr_enable", bus.peripheralEnable, 1);
        check_eq("wr_we", bus.peripheralBus_we, 1);
        check_eq("wr_oe", bus.peripheralBus_oe, 0);
        check_eq("wr_bytesel", bus.peripheralBus_byteSelect, 4'b0011);
        check_eq("wr_datawrite", bus.peripheralBus_dataWrite, 32'h1234_5678);
        check_eq("wr_address", bus.peripheralBus_address, 16'h2010);
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("wr_ack", bus.wb_ack_o, 1);
        check_eq("wr_data_kept", bus.wb_data_o, 32'hA5A5_0001);
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);

        // ---------------- read with busy for three cycles ----------------
        bus.peripheralBus_busy = 1'b1;
        bus.peripheralBus_dataRead = 32'h0BAD_F00D;
        exp_rdata = 32'h0BAD_F00D;
        push_resp(1'b0, exp_rdata);
        drive_req(1'b0, 4'hF, 24'h001008, 32'h0);
        en_cnt = 0; stall_bad = 0; seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.wb_ack_o) begin
                seen = 1;
            end else begin
                if (bus.peripheralEnable) en_cnt++;
                if (!bus.wb_stall_o) stall_bad++;
            end
            if (k == 1) bus.wb_stb_i = 1'b0;
            if (k == 4) bus.peripheralBus_busy = 1'b0;
        end
        check_eq("busy_ack_seen", seen, 1);
        check_eq("busy_enable_cycles", en_cnt, 4);
        check_eq("busy_stall_held", stall_bad, 0);
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);

        // ---------------- abort by dropping cyc ----------------
        bus.peripheralBus_busy = 1'b1;
        bus.peripheralBus_dataRead = 32'h1111_2222;
        drive_req(1'b0, 4'hF, 24'h003000, 32'h0);
        @(negedge clk);
        check_eq("abort_enable_c1", bus.peripheralEnable, 1);
        bus.wb_stb_i = 1'b0;
        @(negedge clk);
        check_eq("abort_enable_c2", bus.peripheralEnable, 1);
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);
        check_eq("abort_enable_off", bus.peripheralEnable, 0);
        check_eq("abort_stall_off", bus.wb_stall_o, 0);
        check_eq("abort_data_kept", bus.wb_data_o, exp_rdata);
        bus.peripheralBus_busy = 1'b0;
        repeat (3) @(negedge clk);
        txn(1'b0, 4'hF, 24'h004020, 32'h0, 32'h1357_9BDF);
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
        // ---------------- timeout with busy stuck ----------------
        bus.peripheralBus_busy = 1'b1;
        bus.peripheralBus_dataRead = 32'h5555_5555;
        exp_rdata = 32'hFFFF_FFFF;
        push_resp(1'b1, exp_rdata);
        drive_req(1'b0, 4'hF, 24'h005000, 32'h0);
        en_cnt = 0; seen = 0; got_ack = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.wb_error_o) seen = 1;
            else if (bus.peripheralEnable) en_cnt++;
            if (bus.wb_ack_o) got_ack = 1;
            if (k == 1) bus.wb_stb_i = 1'b0;
        end
        check_eq("to_error_seen", seen, 1);
        check_eq("to_access_cycles", en_cnt, c_TIMEOUT);
        check_eq("to_no_ack", got_ack, 0);
        check_eq("to_data", bus.wb_data_o, 32'hFFFF_FFFF);
        bus.peripheralBus_busy = 1'b0;
        bus.wb_cyc_i = 1'b0;
        @(negedge clk);
`endif

        // ---------------- reset mid-access ----------------
        bus.peripheralBus_busy = 1'b1;
        drive_req(1'b0, 4'hF, 24'h006000, 32'h0);
        @(negedge clk);
        check_eq("mr_enable_before", bus.peripheralEnable, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mr_enable_async", bus.peripheralEnable, 0);
        check_eq("mr_oe_async", bus.peripheralBus_oe, 0);
        check_eq("mr_address_async", bus.peripheralBus_address, 0);
        check_eq("mr_stall_async", bus.wb_stall_o, 0);
        check_eq("mr_data_async", bus.wb_data_o, 0);
        exp_rdata = '0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.peripheralBus_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 4'hF, 24'h007000, 32'h0, 32'hAAAA_0001);
        txn(1'b0, 4'h3, 24'h007004, 32'h0, 32'hAAAA_0002);
        bus.wb_cyc_i = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
